xvec2_param_vecfile: RTL and testbench
======================================

# xvec2_param_vecfile

Parametrised vector register file for the xvec2 vector extension of the vscale core: NREGS scalar words grouped into lanes of VEC_SIZE, two combinational vector read ports, one lane-masked vector write port. Compared with the fixed 4-lane file, it adds:
- a generic lane count;
- optional same-cycle write-to-read bypass;
- a self-timed clear sequencer that zeroes the file after reset or on request, with a busy indication for the decode stall logic.

## Interface
- XPR_LEN, 32, bits per scalar lane.
- NREGS, 32, scalar words stored; power of two.
- VEC_SIZE, 4, lanes per vector register; power of two, at least 2, divides NREGS.
- BYPASS, 1, 1 = read ports forward the accepted same-cycle write; 0 = no forwarding.
- Derived: AW = clog2(NREGS); LW = clog2(VEC_SIZE); NGROUPS = NREGS/VEC_SIZE.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  single-cycle request to zero the whole file.
- busy  out  1  clear sequence in progress; writes are dropped, reads return zero.
- ra1, ra2  in  AW  read addresses; low LW bits ignored.
- rd1, rd2  out  VEC_SIZE*XPR_LEN  read data; lane i occupies bits [i*XPR_LEN +: XPR_LEN].
- wen  in  1  write enable.
- wa  in  AW  write address; low LW bits ignored.
- wmask  in  VEC_SIZE  per-lane write enable.
- wd  in  VEC_SIZE*XPR_LEN  write data, same lane packing as rd.

## Operation
- Group index is addr[AW-1:LW]. Group 0 is hardwired zero: reads of group 0 return all zeros, and writes to group 0 are discarded.
- FSM states:
  - CLEAR: busy=1; counter cnt walks groups 1..NGROUPS-1, zeroing one whole group per cycle; moves to IDLE after the write to group NGROUPS-1.
  - IDLE: busy=0; normal operation; clr=1 moves to CLEAR with cnt=1.
- A write is accepted when state=IDLE, wen=1, clr=0 and the group is nonzero. Lane i is written iff wmask[i]; lanes with wmask[i]=0 keep their contents.
- clr and wen in the same IDLE cycle: clr wins and the write is dropped. clr while in CLEAR is ignored; the sequence does not restart.
- Reads:
  - While busy, rd1 and rd2 are forced to 0.
  - Otherwise each port returns the stored group.
  - With BYPASS=1 and an accepted write to the same group, lane i returns wd lane i where wmask[i]=1. rd1 and rd2 bypass independently.
- Array contents are not reset. The CLEAR sequence is the only initialisation.

## Timing
- Reset value: state=CLEAR, cnt=1, busy=1, rd1=rd2=0.
- Clear latency:
  - NGROUPS-1 rising edges after reset deassertion, or after the edge sampling clr; 7 with defaults.
  - busy falls in the cycle after the last group is zeroed.
  - Degenerate NGROUPS=1: CLEAR lasts one cycle with no writes.
- Write latency: one edge; data is visible on the read ports from the next cycle. With BYPASS=1 it is also visible in the same cycle, combinationally from wen/wa/wmask/wd.
- Read latency: zero (combinational from ra and array state).
- Reset asserted mid-clear or mid-operation: immediately returns to CLEAR with cnt=1. Partially cleared groups are re-cleared.
- Simultaneous read and write to the same group with BYPASS=0: the read returns the old contents.

## Structure
- Shared header xvec2_defines.vh holds:
  - default XPR_LEN, VEC_SIZE, NREGS;
  - the REG_ADDR_WIDTH derivation;
  - FSM state encodings (ST_IDLE, ST_CLEAR).
- Sub-module xvec2_vecfile_clear_fsm: state register, group counter, busy, and the clear write-enable/index outputs. The top level holds the storage array (NREGS x XPR_LEN), lane-indexed read muxes, and the generate-loop lane write and bypass logic.

## Test plan
- Reset release: busy=1 for exactly 7 cycles with defaults, then 0. Reads of every group return 0; a wen during busy leaves the array unchanged after busy falls.
- Masked write: wa=5 (group 1), wmask=4'b0101, wd lanes 0..3 = {A0,B1,C2,D3}; then a full write wmask=4'b1111. Reading ra1=4 after the masked write returns lanes {A0,0,C2,0}; after the full write all four lanes are updated.
- Zero group: write wa=2, wmask=4'b1111, wd lanes 0..3 = all FFFFFFFF. Reading ra1=0 and ra2=3 returns 0 on both ports.
- Bypass with BYPASS=1: wen to group 2, wmask=4'b0010, wd lane 1=12345678, while ra1=8. rd1 lane 1=12345678 in the same cycle and the other lanes show stored data. Repeated with BYPASS=0: rd1 shows the old lane 1.
- clr with wen in the same cycle (write to group 3): the write is dropped; busy=1 for 7 cycles; group 3 reads 0 afterward.
- Reset asserted on cycle 3 of a clear sequence: busy stays 1 for a full 7 cycles after deassertion, and every group reads 0 afterward.

Source files
------------

// File: rtl/xvec2_param_vecfile_pkg.sv
// Shared defaults, clear-FSM state encoding and width helpers for the xvec2
// parametrised vector register file.
package xvec2_param_vecfile_pkg;

  localparam int unsigned DEF_XPR_LEN  = 32;
  localparam int unsigned DEF_NREGS    = 32;
  localparam int unsigned DEF_VEC_SIZE = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Width of a scalar register address for a file of n words.
  function automatic int unsigned reg_addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Group index width; kept at least one bit so a single-group file still
  // has a legal counter and index.
  function automatic int unsigned group_width(input int unsigned ngroups);
    return (ngroups > 1) ? $clog2(ngroups) : 1;
  endfunction

endpackage

// File: rtl/xvec2_param_vecfile_clear_fsm.sv
// Self-timed clear sequencer: walks groups 1..NGROUPS-1 zeroing one group per
// cycle after reset or a clr request, and flags busy to the decode stall logic.
module xvec2_param_vecfile_clear_fsm
  import xvec2_param_vecfile_pkg::*;
#(
  parameter int unsigned NGROUPS = 8,
  parameter int unsigned CW      = group_width(NGROUPS)
) (
  input  logic          clk,
  input  logic          i_reset,
  input  logic          i_clr,
  output logic          o_busy,
  output logic          o_clr_we,
  output logic [CW-1:0] o_clr_grp
);

  localparam logic [CW-1:0] FIRST_GRP = CW'(1);
  localparam logic [CW-1:0] LAST_GRP  = CW'(NGROUPS - 1);

  state_e        r_state;
  state_e        w_state_d;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_CLEAR;
      r_cnt   <= FIRST_GRP;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // NOTE: every comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      ST_CLEAR: begin
        // A clr seen here is ignored; the running sequence is not restarted.
        if (r_cnt >= LAST_GRP) w_state_d = ST_IDLE;
        else                   w_cnt_d   = r_cnt + 1'b1;
      end
      ST_IDLE: begin
        if (i_clr) begin
          w_state_d = ST_CLEAR;
          w_cnt_d   = FIRST_GRP;
        end
      end
      default: begin
        w_state_d = ST_CLEAR;
        w_cnt_d   = FIRST_GRP;
      end
    endcase
  end

  // A single-group file has nothing to zero, so CLEAR is one idle-busy cycle.
  always_comb begin
    o_busy   = 1'b0;
    o_clr_we = 1'b0;
    if (r_state == ST_CLEAR) begin
      o_busy   = 1'b1;
      o_clr_we = (NGROUPS > 1);
    end
  end

  assign o_clr_grp = r_cnt;

endmodule

// File: rtl/xvec2_param_vecfile.sv
// Parametrised xvec2 vector register file: two combinational vector read
// ports, one lane-masked write port, optional write bypass and self-clear.
module xvec2_param_vecfile
  import xvec2_param_vecfile_pkg::*;
#(
  parameter  int unsigned XPR_LEN  = DEF_XPR_LEN,
  parameter  int unsigned NREGS    = DEF_NREGS,
  parameter  int unsigned VEC_SIZE = DEF_VEC_SIZE,
  parameter  int unsigned BYPASS   = 1,
  localparam int unsigned AW       = reg_addr_width(NREGS),
  localparam int unsigned DW       = VEC_SIZE * XPR_LEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  output logic                busy,
  input  logic [AW-1:0]       ra1,
  input  logic [AW-1:0]       ra2,
  output logic [DW-1:0]       rd1,
  output logic [DW-1:0]       rd2,
  input  logic                wen,
  input  logic [AW-1:0]       wa,
  input  logic [VEC_SIZE-1:0] wmask,
  input  logic [DW-1:0]       wd
);

  localparam int unsigned LW      = $clog2(VEC_SIZE);
  localparam int unsigned NGROUPS = NREGS / VEC_SIZE;
  localparam int unsigned CW      = group_width(NGROUPS);

  logic          w_busy;
  logic          w_clr_we;
  logic [CW-1:0] w_clr_grp;
  logic [CW-1:0] w_ra1_grp;
  logic [CW-1:0] w_ra2_grp;
  logic [CW-1:0] w_wa_grp;
  logic          w_ra1_zero;
  logic          w_ra2_zero;
  logic          w_wr_acc;
  logic          w_unused_lane_bits;

  xvec2_param_vecfile_clear_fsm #(
    .NGROUPS (NGROUPS),
    .CW      (CW)
  ) u_clear_fsm (
    .clk       (clk),
    .i_reset   (reset),
    .i_clr     (clr),
    .o_busy    (w_busy),
    .o_clr_we  (w_clr_we),
    .o_clr_grp (w_clr_grp)
  );

  assign busy = w_busy;

  // Lane-select bits of every address are ignored; only the group matters.
  assign w_ra1_grp  = CW'(ra1 >> LW);
  assign w_ra2_grp  = CW'(ra2 >> LW);
  assign w_wa_grp   = CW'(wa >> LW);
  assign w_ra1_zero = (w_ra1_grp == '0);
  assign w_ra2_zero = (w_ra2_grp == '0);

  assign w_unused_lane_bits = ^{ra1[LW-1:0], ra2[LW-1:0], wa[LW-1:0]};

  // Group 0 is hardwired zero and a same-cycle clr wins over the write.
  assign w_wr_acc = !w_busy && wen && !clr && (w_wa_grp != '0);

  for (genvar i = 0; i < VEC_SIZE; i++) begin : g_lane
    logic [XPR_LEN-1:0] r_lane [NGROUPS];
    logic [XPR_LEN-1:0] w_wd_lane;
    logic [XPR_LEN-1:0] w_rd1_lane;
    logic [XPR_LEN-1:0] w_rd2_lane;
    logic               w_lane_we;
    logic               w_byp1;
    logic               w_byp2;

    assign w_wd_lane = wd[i*XPR_LEN +: XPR_LEN];
    assign w_lane_we = w_wr_acc && wmask[i];
    assign w_byp1    = (BYPASS != 0) && w_lane_we && (w_wa_grp == w_ra1_grp);
    assign w_byp2    = (BYPASS != 0) && w_lane_we && (w_wa_grp == w_ra2_grp);

    // NOTE: the storage array has no reset; the clear sequencer is its only
    // initialisation, which keeps it mappable onto plain RAM/flop arrays.
    always_ff @(posedge clk) begin
      if (w_clr_we)       r_lane[w_clr_grp] <= '0;
      else if (w_lane_we) r_lane[w_wa_grp]  <= w_wd_lane;
    end

    always_comb begin
      w_rd1_lane = w_byp1 ? w_wd_lane : r_lane[w_ra1_grp];
      if (w_busy || w_ra1_zero) w_rd1_lane = '0;
    end

    always_comb begin
      w_rd2_lane = w_byp2 ? w_wd_lane : r_lane[w_ra2_grp];
      if (w_busy || w_ra2_zero) w_rd2_lane = '0;
    end

    assign rd1[i*XPR_LEN +: XPR_LEN] = w_rd1_lane;
    assign rd2[i*XPR_LEN +: XPR_LEN] = w_rd2_lane;
  end

endmodule

// File: tb/tb_xvec2_param_vecfile.sv
// Self-checking bench: two instances (BYPASS=1 and BYPASS=0) share stimulus
// and are compared every cycle against a group/lane array model.
module tb_xvec2_param_vecfile;

  localparam int NG = 8;
  localparam int NL = 4;
  localparam int CLEAR_CYCLES = NG - 1;

  logic         clk;
  logic         reset;
  logic         clr;
  logic         wen;
  logic [4:0]   ra1, ra2, wa;
  logic [3:0]   wmask;
  logic [127:0] wd;
  logic         busy_b, busy_n;
  logic [127:0] rd1_b, rd2_b, rd1_n, rd2_n;

  int n_pass;
  int n_total;

  logic [31:0] m_mem [NG][NL];
  int          m_busy;

  xvec2_param_vecfile #(.BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .clr(clr), .busy(busy_b),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .wen(wen), .wa(wa), .wmask(wmask), .wd(wd)
  );

  xvec2_param_vecfile #(.BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .clr(clr), .busy(busy_n),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
    .wen(wen), .wa(wa), .wmask(wmask), .wd(wd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic clear_model();
    for (int g = 0; g < NG; g++)
      for (int l = 0; l < NL; l++) m_mem[g][l] = '0;
  endtask

  // Expected read data from the current inputs and model contents.
  function automatic logic [127:0] exp_rd(input logic [4:0] ra, input bit byp);
    logic [127:0] r;
    int           g;
    bit           acc;
    r   = '0;
    g   = int'(ra) / NL;
    acc = (m_busy == 0) && wen && !clr && (int'(wa) / NL != 0);
    if (m_busy != 0 || g == 0) return r;
    for (int l = 0; l < NL; l++) begin
      r[l*32 +: 32] = m_mem[g][l];
      if (byp && acc && int'(wa) / NL == g && wmask[l]) r[l*32 +: 32] = wd[l*32 +: 32];
    end
    return r;
  endfunction

  // Compare all outputs before the edge, then advance model across the edge.
  task automatic cycle();
    int g;
    #1;
    check("busy_b", 128'(busy_b), 128'(m_busy != 0));
    check("busy_n", 128'(busy_n), 128'(m_busy != 0));
    check("rd1_b", rd1_b, exp_rd(ra1, 1'b1));
    check("rd2_b", rd2_b, exp_rd(ra2, 1'b1));
    check("rd1_n", rd1_n, exp_rd(ra1, 1'b0));
    check("rd2_n", rd2_n, exp_rd(ra2, 1'b0));
    @(posedge clk);
    g = int'(wa) / NL;
    if (m_busy > 0) m_busy--;
    else if (clr) begin
      clear_model();
      m_busy = CLEAR_CYCLES;
    end else if (wen && g != 0) begin
      for (int l = 0; l < NL; l++)
        if (wmask[l]) m_mem[g][l] = wd[l*32 +: 32];
    end
    #1;
  endtask

  task automatic idle_inputs();
    clr = 0; wen = 0; wmask = '0; wd = '0; wa = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_model();
    m_busy = CLEAR_CYCLES;
    #2;
    check("rst_busy", 128'(busy_b), 128'(1));
    check("rst_rd1", rd1_b, '0);
    check("rst_rd2_n", rd2_n, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Walk a clear sequence while trying to write group 1; busy must last exactly 7 cycles.
  task automatic run_clear(input string tag);
    for (int k = 0; k < CLEAR_CYCLES; k++) begin
      clr = 0; wen = 1; wa = 5'd4; wmask = 4'hF; wd = {4{32'hFFFF_FFFF}};
      ra1 = 5'(4 * (k % NG)); ra2 = 5'($urandom);
      #1;
      check({tag, "_busy_hi"}, 128'(busy_b), 128'(1));
      cycle();
    end
    idle_inputs();
    #1;
    check({tag, "_busy_lo"}, 128'(busy_b), 128'(0));
  endtask

  task automatic read_all(input string tag);
    idle_inputs();
    for (int g = 0; g < NG; g++) begin
      ra1 = 5'(g * NL + $urandom_range(0, 3));
      ra2 = 5'(((NG - 1 - g) * NL) + $urandom_range(0, 3));
      #1;
      check({tag, "_rd1_zero"}, rd1_n, '0);
      check({tag, "_rd2_zero"}, rd2_b, '0);
      cycle();
    end
  endtask

  logic [127:0] stored;

  initial begin
    n_pass = 0; n_total = 0;
    reset = 0; ra1 = '0; ra2 = '0;
    idle_inputs();
    m_busy = 0;
    clear_model();
    #1;

    // Reset release, dropped writes while busy, every group zero.
    do_reset();
    run_clear("rst");
    read_all("rst");

    // Masked then full write to group 1.
    wen = 1; wa = 5'd5; wmask = 4'b0101; ra1 = 5'd4; ra2 = 5'd0;
    wd = {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};
    cycle();
    idle_inputs();
    #1;
    check("masked", rd1_b, {32'h0, 32'hC2C2_C2C2, 32'h0, 32'hA0A0_A0A0});
    cycle();
    wen = 1; wa = 5'd6; wmask = 4'b1111;
    wd = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    cycle();
    idle_inputs();
    #1;
    check("full", rd1_n, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
    cycle();

    // Writes to group 0 are discarded.
    wen = 1; wa = 5'd2; wmask = 4'hF; wd = {4{32'hFFFF_FFFF}}; ra1 = 5'd0; ra2 = 5'd3;
    cycle();
    idle_inputs();
    #1;
    check("zero_grp_rd1", rd1_b, '0);
    check("zero_grp_rd2", rd2_b, '0);
    cycle();

    // Bypass: preload group 2, then partial write while reading it.
    stored = {32'h0D0D_0D0D, 32'h0C0C_0C0C, 32'h0B0B_0B0B, 32'h0A0A_0A0A};
    wen = 1; wa = 5'd8; wmask = 4'hF; wd = stored;
    cycle();
    wen = 1; wa = 5'd9; wmask = 4'b0010; ra1 = 5'd8; ra2 = 5'd11;
    wd = {$urandom, $urandom, 32'h1234_5678, $urandom};
    #1;
    check("byp_on", rd1_b, {stored[127:64], 32'h1234_5678, stored[31:0]});
    check("byp_off", rd1_n, stored);
    cycle();
    idle_inputs();
    #1;
    check("byp_after", rd1_n, {stored[127:64], 32'h1234_5678, stored[31:0]});
    cycle();

    // clr with a same-cycle write to group 3: write dropped, file cleared.
    wen = 1; wa = 5'd12; wmask = 4'hF; wd = {4{32'h5A5A_5A5A}};
    cycle();
    clr = 1; wen = 1; wa = 5'd13; wd = {4{32'h6B6B_6B6B}}; ra1 = 5'd12;
    cycle();
    run_clear("clr");
    ra1 = 5'd12; ra2 = 5'd14;
    #1;
    check("clr_grp3", rd1_b, '0);
    cycle();

    // Randomised traffic with occasional clr.
    for (int k = 0; k < 300; k++) begin
      clr   = ($urandom_range(0, 49) == 0);
      wen   = ($urandom_range(0, 3) != 0);
      wa    = 5'($urandom);
      wmask = 4'($urandom);
      wd    = {$urandom, $urandom, $urandom, $urandom};
      ra1   = $urandom_range(0, 1) ? wa : 5'($urandom);
      ra2   = $urandom_range(0, 2) == 0 ? wa : 5'($urandom);
      cycle();
    end

    // Reset on cycle 3 of a clear: full 7-cycle re-clear afterwards.
    idle_inputs();
    while (m_busy != 0) cycle();
    for (int g = 1; g < NG; g++) begin
      wen = 1; wa = 5'(g * NL); wmask = 4'hF; wd = {4{$urandom}};
      cycle();
    end
    idle_inputs();
    clr = 1;
    cycle();
    clr = 0;
    repeat (2) cycle();
    do_reset();
    run_clear("mid");
    read_all("mid");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
